apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Two-port APB requester arbiter and master sequencer that shares one apb_slave register bank between two internal requesters.
- Arbitrates between the requesters round-robin.
- Drives the APB SETUP/ACCESS phase sequence on the slave side and returns read data plus a completion ack to the winning requester.
- Sits directly in front of apb_slave (clk, rst_n, paddr, pwrite, psel, penable, pwdata, prdata). That slave has no pready or pslverr, so every ACCESS phase lasts exactly one cycle.

Parameters:
- ADDR_W, 8, width of the APB address and the requester addresses.
- DATA_W, 32, width of the write and read data buses.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a pending transfer; held high until req0_ack.
- req0_write  in  1  requester 0 direction (1 = write).
- req0_addr  in  ADDR_W  requester 0 address.
- req0_wdata  in  DATA_W  requester 0 write data.
- req0_ack  out  1  one-cycle completion pulse for requester 0.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ack  same as requester 0, for requester 1.
- rdata  out  DATA_W  read data of the last completed read; valid while reqN_ack is high.
- busy  out  1  high in every state except IDLE.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data from the slave.

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous and active-low. While rst_n is low:
  - State = IDLE.
  - psel, penable, pwrite, paddr, pwdata, rdata, req0_ack, req1_ack and busy are all 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - psel = 0, penable = 0.
  - If any reqN_valid is high on a rising edge, select a winner:
    - only one valid: that requester wins;
    - both valid: the requester != last_grant wins.
  - On that edge:
    - latch the winner's write/addr/wdata into pwrite/paddr/pwdata;
    - update last_grant to the winner;
    - go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - psel = 1, penable = 0.
  - Always go to ACCESS on the next edge.
- ACCESS:
  - psel = 1, penable = 1.
  - On the next edge:
    - if pwrite = 0, capture prdata into rdata; on a write, rdata holds its previous value;
    - set ack for the granted requester;
    - go to DONE.
- DONE:
  - psel = 0, penable = 0.
  - The granted requester's ack is high for exactly this cycle.
  - No arbitration takes place in DONE.
  - Always go to IDLE.
- Handshake:
  - A requester must keep valid high and the payload stable until it samples its ack.
  - On the edge where its ack = 1, the requester drops valid or presents a new request.
  - Payload changes after the IDLE->SETUP edge are ignored.
  - Dropping valid before ack does not cancel a granted transfer; the transfer completes and the ack is still issued.
- Latency and throughput:
  - psel rises 1 cycle after valid is sampled in IDLE.
  - ack arrives 3 cycles after valid is sampled in IDLE.
  - Minimum 4 cycles per transfer (IDLE, SETUP, ACCESS, DONE).
- paddr, pwrite and pwdata hold their values from SETUP through DONE and into IDLE until the next grant. They do not return to 0.
- rdata holds until the next read completes.
- A requester that asserts valid during SETUP/ACCESS/DONE waits until the next IDLE.
- Fairness: with both requesters permanently valid, grants strictly alternate 0,1,0,1. A single valid requester is granted every transfer regardless of last_grant.
- Reset mid-operation (any state): all outputs return to their reset values immediately (asynchronous) and the transfer is abandoned with no ack. After release, arbitration restarts with last_grant = 1.

Test Plan:
- Single write: req0 write, addr 0x05, wdata 0x12345678 from reset.
  - Required: psel = 1 at cycle +1; penable = 1 at cycle +2; paddr = 0x05 and pwdata = 0x12345678 stable throughout; req0_ack pulses one cycle at cycle +3; slave reg[5] = 0x12345678.
- Read-back: after writing 0xA5A5A5A5 to addr 0x10, req1 reads addr 0x10.
  - Required: pwrite = 0 during SETUP/ACCESS; rdata = 0xA5A5A5A5 while req1_ack = 1; req0_ack stays 0.
- Simultaneous request after reset: req0 and req1 both valid in the same cycle.
  - Required: req0 is served first (ack at cycle +3); req1 is served next (ack at cycle +7); exactly 2 acks total.
- Sustained contention: both requesters keep valid high for 8 transfers, each presenting a new address after every ack.
  - Required: ack order 0,1,0,1,0,1,0,1; psel never high in DONE or IDLE.
- Reset mid-ACCESS: assert rst_n low while penable = 1.
  - Required: psel, penable and ack are 0 in the same cycle; no ack after release; the next simultaneous request is granted to req0.
- Payload change after grant: req0 changes addr from 0x03 to 0x3F during SETUP.
  - Required: paddr stays 0x03 through ACCESS.

Source files
------------

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter that shares one APB slave between two requesters
module apb_rr_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic r_last;
  logic w_any, w_win;
  assign w_any = req0_valid | req1_valid;
  assign w_win = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  // next state: only IDLE waits on requests, the rest of the sequence is fixed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_any ? SETUP : IDLE;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // grant bookkeeping and payload latch on the IDLE->SETUP edge; r_last also names the active requester
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_last <= 1'b1;
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_last <= w_win;
      pwrite <= w_win ? req1_write : req0_write;
      paddr  <= w_win ? req1_addr : req0_addr;
      pwdata <= w_win ? req1_wdata : req0_wdata;
    end
  // phase outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      psel     <= 1'b0;
      penable  <= 1'b0;
      busy     <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
    end else begin
      psel     <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
      penable  <= w_state_nxt == ACCESS;
      busy     <= w_state_nxt != IDLE;
      req0_ack <= (r_state == ACCESS) && !r_last;
      req1_ack <= (r_state == ACCESS) && r_last;
    end
  // read data captured at the end of ACCESS, held across writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (r_state == ACCESS && !pwrite) rdata <= prdata;
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: random and directed traffic checked cycle by cycle against a transaction-timing model
module tb_apb_rr_master;
  logic        clk = 0, rst_n = 0, s_clr = 0;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [7:0]  req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0;
  logic        req0_ack, req1_ack, busy, psel, penable, pwrite;
  logic [31:0] rdata, pwdata, prdata;
  logic [7:0]  paddr;
  int n_cmp = 0, n_bad = 0;
  int ack_q[$];
  int ack_n[$];

  apb_rr_master dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack),
    .rdata(rdata), .busy(busy), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata)
  );

  always #5 clk = ~clk;

  // slave register bank: combinational read, write at the end of ACCESS
  logic [31:0] s_mem [256];
  assign prdata = s_mem[paddr];
  always @(posedge clk)
    if (s_clr) for (int i = 0; i < 256; i++) s_mem[i] <= 32'hC0DE0000 | 32'(i);
    else if (psel && penable && pwrite) s_mem[paddr] <= pwdata;

  // reference model: each grant occupies cycles g (SETUP), g+1 (ACCESS), g+2 (DONE);
  // a new grant may be taken in any cycle from g+3 on
  int t, g;
  logic m_last, m_write;
  logic [7:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [31:0] m_mem [256];
  wire m_w = (req0_valid && req1_valid) ? !m_last : req1_valid;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t <= 0; g <= -100; m_last <= 1; m_write <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0;
    end else begin
      t <= t + 1;
      if (s_clr) for (int i = 0; i < 256; i++) m_mem[i] <= 32'hC0DE0000 | 32'(i);
      if (t == g + 1) begin
        if (m_write) m_mem[m_addr] <= m_wdata;
        else m_rdata <= m_mem[m_addr];
      end
      if (t >= g + 3 && (req0_valid || req1_valid)) begin
        m_last  <= m_w;
        g       <= t + 1;
        m_write <= m_w ? req1_write : req0_write;
        m_addr  <= m_w ? req1_addr : req0_addr;
        m_wdata <= m_w ? req1_wdata : req0_wdata;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("psel", psel, (t == g) || (t == g + 1));
      chk("penable", penable, t == g + 1);
      chk("busy", busy, (t >= g) && (t <= g + 2));
      chk("ack0", req0_ack, (t == g + 2) && !m_last);
      chk("ack1", req1_ack, (t == g + 2) && m_last);
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_write);
      chk("pwdata", pwdata, m_wdata);
      chk("rdata", rdata, m_rdata);
    end

  task automatic rnd0();
    req0_write = 1'($urandom_range(0, 1)); req0_addr = 8'($urandom_range(0, 15)); req0_wdata = $urandom;
  endtask
  task automatic rnd1();
    req1_write = 1'($urandom_range(0, 1)); req1_addr = 8'($urandom_range(0, 15)); req1_wdata = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // requester 0 issues c0 and requester 1 issues c1 back-to-back transfers; requester 1 starts d1 cycles late
  task automatic serve(input int c0, input int c1, input int d1);
    int left0 = c0, left1 = c1, n = 0;
    bit a0, a1;
    ack_q.delete(); ack_n.delete();
    req0_valid = c0 > 0;
    req1_valid = (c1 > 0) && (d1 == 0);
    while ((left0 > 0 || left1 > 0) && n < 200) begin
      @(negedge clk);
      a0 = req0_ack; a1 = req1_ack;
      if (a0) begin ack_q.push_back(0); ack_n.push_back(n); end
      if (a1) begin ack_q.push_back(1); ack_n.push_back(n); end
      @(posedge clk); #1;
      n++;
      if (a0) begin left0--; if (left0 > 0) rnd0(); else req0_valid = 0; end
      if (a1) begin left1--; if (left1 > 0) rnd1(); else req1_valid = 0; end
      if (n == d1 && c1 > 0) req1_valid = 1;
    end
    chk("serve_done", 32'(left0 > 0 || left1 > 0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", psel, 0); chk("rst_penable", penable, 0); chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0); chk("rst_rdata", rdata, 0);
    chk("rst_ack0", req0_ack, 0); chk("rst_ack1", req1_ack, 0); chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1; s_clr = 1;
    @(posedge clk); #1;
    s_clr = 0;
    // single write from reset
    req0_write = 1; req0_addr = 8'h05; req0_wdata = 32'h12345678;
    serve(1, 0, 0);
    chk("wr_ack_lat", ack_n.size() == 1 ? ack_n[0] : -1, 3);
    chk("wr_slave", s_mem[5], 32'h12345678);
    // write then read-back by requester 1
    req0_write = 1; req0_addr = 8'h10; req0_wdata = 32'hA5A5A5A5;
    serve(1, 0, 0);
    req1_write = 0; req1_addr = 8'h10; req1_wdata = 32'h0;
    serve(0, 1, 0);
    chk("rb_nacks", ack_q.size(), 1);
    chk("rb_who", ack_q.size() == 1 ? ack_q[0] : -1, 1);
    chk("rb_rdata", rdata, 32'hA5A5A5A5);
    // simultaneous request right after reset
    do_reset();
    rnd0(); rnd1();
    serve(1, 1, 0);
    chk("sim_nacks", ack_q.size(), 2);
    chk("sim_first", ack_q.size() == 2 ? ack_q[0] : -1, 0);
    chk("sim_lat0", ack_n.size() == 2 ? ack_n[0] : -1, 3);
    chk("sim_lat1", ack_n.size() == 2 ? ack_n[1] : -1, 7);
    // reset in the middle of ACCESS
    rnd0(); rnd1();
    req0_valid = 1; req1_valid = 1;
    w = 0;
    do begin @(negedge clk); w++; end while (!penable && w < 10);
    chk("mid_pen_seen", penable, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_psel", psel, 0); chk("mid_penable", penable, 0);
    chk("mid_ack0", req0_ack, 0); chk("mid_ack1", req1_ack, 0); chk("mid_busy", busy, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    // sustained contention after release: strict alternation starting with requester 0
    rnd0(); rnd1();
    serve(4, 4, 0);
    chk("alt_nacks", ack_q.size(), 8);
    for (int i = 0; i < ack_q.size(); i++) chk("alt_order", ack_q[i], i % 2);
    // payload change after grant
    req0_write = 1; req0_addr = 8'h03; req0_wdata = 32'hDEADBEEF; req0_valid = 1;
    @(posedge clk); #1;
    req0_addr = 8'h3F;
    @(negedge clk); chk("hold_setup", paddr, 8'h03);
    @(negedge clk); chk("hold_access", paddr, 8'h03);
    @(negedge clk); chk("hold_ack", req0_ack, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    // valid dropped after grant: transfer still completes
    rnd1(); req1_valid = 1;
    @(posedge clk); #1;
    req1_valid = 0;
    w = 0;
    do begin @(negedge clk); w++; end while (!req1_ack && w < 10);
    chk("drop_ack", req1_ack, 1);
    @(posedge clk); #1;
    // random traffic
    for (int k = 0; k < 60; k++) begin
      int c0, c1;
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(c0 == 0 ? 1 : 0, 3);
      rnd0(); rnd1();
      serve(c0, c1, $urandom_range(0, 6));
      chk("rnd_nacks", ack_q.size(), c0 + c1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
